dmem_sized: RTL and testbench

DMEM_SIZED -- requirements
Module: dmem_sized

---
 rtl/dmem_sized.sv | 198 +++++++++++++++++++
 tb/tb_dmem_sized.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized.sv
// +--------------------------------------------------------------------------+
// | dmem_sized : byte/half/word data memory with self-clearing init          |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_sized #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int            c_AW       = $clog2(DEPTH_WORDS);
  localparam logic [c_AW-1:0] c_LAST_IDX = c_AW'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_AW-1:0]   r_clr_idx;
  logic [c_AW-1:0]   w_clr_idx_nxt;
  logic              w_clear_en;

  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_accept;
  logic [c_AW-1:0]   w_idx;
  logic              w_oob;
  logic              w_misalign;
  logic              w_err;
  logic              w_store_ok;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;
  logic [31:0]       w_rword;
  logic [31:0]       w_shifted;
  logic [31:0]       w_ldata;
  logic [31:0]       w_rsp_data;

  logic              r_s1_valid;
  logic              r_s1_err;
  logic [31:0]       r_s1_data;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_INIT;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clear_en    = 1'b0;
    req_ready     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clear_en    = 1'b1;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (r_clr_idx == c_LAST_IDX) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // ---------------- request decode ----------------
  assign w_accept   = req_valid & req_ready;
  assign w_idx      = req_addr[c_AW+1:2];
  // Any set bit above the index range is out of range; addresses never alias.
  assign w_oob      = |req_addr[31:c_AW+2];
  assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err      = (req_size == 2'b11) | w_misalign | w_oob;
  assign w_store_ok = w_accept & req_we & ~w_err;

  always_comb begin
    w_be    = 4'b0000;
    w_wlane = '0;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = req_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = '0;
      end
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_clear_en) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_store_ok) begin
        for (int b = 0; b < 4; b++) begin
          if (w_be[b]) begin
            r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
          end
        end
      end
    end
  end

  // Read happens at acceptance, so a store on the previous edge is already visible.
  assign w_rword   = r_mem[w_idx];
  assign w_shifted = w_rword >> {req_addr[1:0], 3'b000};

  always_comb begin
    w_ldata = '0;
    case (req_size)
      2'b00:   w_ldata = {{24{w_shifted[7] & ~req_unsigned}}, w_shifted[7:0]};
      2'b01:   w_ldata = {{16{w_shifted[15] & ~req_unsigned}}, w_shifted[15:0]};
      2'b10:   w_ldata = w_rword;
      default: w_ldata = '0;
    endcase
  end

  assign w_rsp_data = (req_we | w_err) ? 32'd0 : w_ldata;

  // ---------------- response pipeline ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= w_accept & w_err;
      r_s1_data  <= w_accept ? w_rsp_data : 32'd0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic        r_s2_valid;
      logic        r_s2_err;
      logic [31:0] r_s2_data;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          r_s2_data  <= r_s1_data;
        end
      end

      assign rsp_valid = r_s2_valid;
      assign rsp_err   = r_s2_err;
      assign rsp_rdata = r_s2_data;
    end else begin : g_lat1
      assign rsp_valid = r_s1_valid;
      assign rsp_err   = r_s1_err;
      assign rsp_rdata = r_s1_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dmem_sized.sv
// +--------------------------------------------------------------------------+
// | tb_dmem_sized : directed and random checks of dmem_sized, latency 1 and 2 |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_sized;

  localparam int DEPTH = 16;
  localparam int NBYTE = 4 * DEPTH;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, rv1, re1;
  logic [31:0] rd1;
  logic        rdy2, rv2, re2;
  logic [31:0] rd2;

  dmem_sized #(.DEPTH_WORDS(DEPTH), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1)
  );

  dmem_sized #(.DEPTH_WORDS(DEPTH), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: byte array, remaining init cycles, and expected responses
  // keyed by the cycle they are due in (index 0 = latency 1, 1 = latency 2).
  logic [7:0]  mem_m [NBYTE];
  int          init_cnt;
  int          c;
  logic        e_v [2][8];
  logic        e_e [2][8];
  logic [31:0] e_d [2][8];
  logic        d_v [2][8];
  logic        d_e [2][8];
  logic [31:0] d_d [2][8];

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, c);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_access(input logic we, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic err, output logic [31:0] data);
    int          nb;
    int          base;
    logic [31:0] raw;
    err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
           (sz == 2'b10 && a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    data = 32'd0;
    if (!err) begin
      nb   = 1 << sz;
      base = int'(a[15:0]);
      raw  = 32'd0;
      for (int i = 0; i < nb; i++) begin
        if (we) mem_m[base + i] = wd[8*i +: 8];
        else    raw[8*i +: 8]   = mem_m[base + i];
      end
      if (!we) begin
        data = raw;
        if (nb == 1 && !un) data = {{24{raw[7]}}, raw[7:0]};
        if (nb == 2 && !un) data = {{16{raw[15]}}, raw[15:0]};
      end
    end
  endtask

  task automatic model_reset();
    init_cnt = DEPTH;
    for (int i = 0; i < NBYTE; i++) mem_m[i] = 8'h00;
    for (int l = 0; l < 2; l++) begin
      for (int s = 0; s < 8; s++) begin
        e_v[l][s] = 1'b0; e_e[l][s] = 1'b0; e_d[l][s] = 32'd0;
        d_v[l][s] = 1'b0; d_e[l][s] = 1'b0; d_d[l][s] = 32'd0;
      end
    end
  endtask

  // One clock: check what the previous edge produced, then drive the next edge.
  task automatic step(input logic rn, input logic v, input logic we, input logic [1:0] sz,
                      input logic un, input logic [31:0] a, input logic [31:0] wd,
                      input logic dchk, input logic [31:0] dd, input logic de);
    int          s;
    int          ss;
    logic        acc;
    logic        err;
    logic [31:0] data;
    @(negedge clk);
    c++;
    s = c % 8;
    chk("ready_lat1", 64'(rdy1), 64'(init_cnt == 0));
    chk("ready_lat2", 64'(rdy2), 64'(init_cnt == 0));
    chk("rsp_lat1", {30'd0, rv1, re1, rd1}, {30'd0, e_v[0][s], e_e[0][s], e_d[0][s]});
    chk("rsp_lat2", {30'd0, rv2, re2, rd2}, {30'd0, e_v[1][s], e_e[1][s], e_d[1][s]});
    if (d_v[0][s]) chk("dir_lat1", {31'd0, re1, rd1}, {31'd0, d_e[0][s], d_d[0][s]});
    if (d_v[1][s]) chk("dir_lat2", {31'd0, re2, rd2}, {31'd0, d_e[1][s], d_d[1][s]});
    for (int l = 0; l < 2; l++) begin
      e_v[l][s] = 1'b0; e_e[l][s] = 1'b0; e_d[l][s] = 32'd0; d_v[l][s] = 1'b0;
    end

    rst          = rn;
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;

    acc = rn && v && (init_cnt == 0);
    if (!rn) model_reset();
    else if (init_cnt != 0) init_cnt--;
    if (acc) begin
      model_access(we, sz, un, a, wd, err, data);
      for (int l = 0; l < 2; l++) begin
        ss = (c + 1 + l) % 8;
        e_v[l][ss] = 1'b1; e_e[l][ss] = err; e_d[l][ss] = data;
        d_v[l][ss] = dchk; d_e[l][ss] = de;  d_d[l][ss] = dd;
      end
    end
  endtask

  task automatic idle(input logic rn);
    step(rn, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rq(input logic we, input logic [1:0] sz, input logic un,
                    input logic [31:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, we, sz, un, a, wd, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic rqd(input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    step(1'b1, 1'b1, we, sz, un, a, wd, 1'b1, exp_d, exp_e);
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    n_pass = 0; n_total = 0; c = 0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    model_reset();

    repeat (3) idle(1'b0);
    // A request offered during init must be ignored.
    repeat (5) idle(1'b1);
    rq(1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    repeat (12) idle(1'b1);

    rqd(1'b0, 2'b10, 1'b0, 32'h0000_003C, 32'd0, 32'h0000_0000, 1'b0);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 32'h0000_0000, 1'b0);

    rqd(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0, 1'b0);
    rqd(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0000_0012, 32'h0, 1'b0);
    rqd(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 1'b0);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0, 32'hBEEF_12A5, 1'b0);

    rqd(1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'd0, 32'hFFFF_FFBE, 1'b0);
    rqd(1'b0, 2'b00, 1'b1, 32'h0000_0007, 32'd0, 32'h0000_00BE, 1'b0);
    rqd(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'd0, 32'hFFFF_BEEF, 1'b0);
    rqd(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'd0, 32'h0000_BEEF, 1'b0);

    rqd(1'b1, 2'b10, 1'b0, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0, 1'b1);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0, 32'h0000_0000, 1'b0);
    rqd(1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'd0, 32'h0000_0000, 1'b1);
    rqd(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'd0, 32'h0000_0000, 1'b1);
    rqd(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'd0, 32'h0000_0000, 1'b1);

    rqd(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'h1234_5678, 1'b0);
    repeat (3) idle(1'b1);

    // Load accepted, then reset on the very next edge.
    rq(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0);
    idle(1'b0);
    repeat (DEPTH + 1) idle(1'b1);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'd0, 32'h0000_0000, 1'b0);
    rqd(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 32'h0000_0000, 1'b0);

    // Reset asserted partway through init restarts the full clear.
    repeat (5) idle(1'b1);
    idle(1'b0);
    repeat (7) idle(1'b1);
    idle(1'b0);
    repeat (DEPTH + 2) idle(1'b1);

    for (int n = 0; n < 600; n++) begin
      r = int'($urandom % 16);
      if ($urandom % 8 == 0) sz = 2'b11;
      else                   sz = 2'($urandom % 3);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(4 * DEPTH) + ($urandom % 8);
      else             a = $urandom % NBYTE;
      if ($urandom % 4 != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom % 250 == 0)     idle(1'b0);
      else if ($urandom % 6 == 0)  idle(1'b1);
      else rq(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
    end
    repeat (4) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
